// File: rtl/branch_redirect_ctrl.sv
// Branch/jump redirect sequencer: captures an execute-stage redirect, hands it to
// fetch over valid/ready, flushes IF/ID and ID/EX until the new stream arrives.
module brc_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  // Clear wins over a same-cycle increment; saturate instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_cnt <= '0;
    else if (i_clr)             r_cnt <= '0;
    else if (i_inc && !(&r_cnt)) r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;
endmodule

module branch_redirect_ctrl #(
  parameter int PC_WIDTH     = 6,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid,
  input  logic                 select_new_pc,
  input  logic [PC_WIDTH-1:0]  new_pc,
  input  logic                 fetch_ready,
  input  logic                 clear_stats,
  output logic                 redirect_valid,
  output logic [PC_WIDTH-1:0]  redirect_pc,
  output logic                 flush_if_id,
  output logic                 flush_id_ex,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] taken_count,
  output logic [CNT_WIDTH-1:0] wait_count
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PEND  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam int FLOAD_I = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;
  localparam logic [3:0] FLOAD = 4'(FLOAD_I);

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_flush_cnt;
  logic [PC_WIDTH-1:0] r_pc;
  logic                w_capture, w_hs, w_wait;

  assign w_capture = (r_state == S_IDLE) && ex_valid && select_new_pc;
  assign w_hs      = (r_state == S_PEND) && fetch_ready;
  assign w_wait    = (r_state == S_PEND) && !fetch_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_capture) w_state_nxt = S_PEND;
      S_PEND:  if (w_hs) w_state_nxt = (FLUSH_CYCLES == 0) ? S_IDLE : S_FLUSH;
      S_FLUSH: if (r_flush_cnt == 4'd0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    redirect_valid = 1'b0;
    flush_if_id    = 1'b0;
    flush_id_ex    = 1'b0;
    busy           = 1'b0;
    case (r_state)
      S_PEND: begin
        redirect_valid = 1'b1;
        flush_if_id    = 1'b1;
        flush_id_ex    = 1'b1;
        busy           = 1'b1;
      end
      S_FLUSH: begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        busy        = 1'b1;
      end
      default: ;
    endcase
  end

  // Counter is loaded with FLUSH_CYCLES-1 so FLUSH spans exactly FLUSH_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        r_flush_cnt <= 4'd0;
    else if (w_hs)                                     r_flush_cnt <= FLOAD;
    else if (r_state == S_FLUSH && r_flush_cnt != 4'd0) r_flush_cnt <= r_flush_cnt - 4'd1;
  end

  // Target is only written on capture; it deliberately survives the return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_pc <= '0;
    else if (w_capture) r_pc <= new_pc;
  end

  assign redirect_pc = r_pc;

  brc_sat_cnt #(.W(CNT_WIDTH)) u_taken (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (clear_stats),
    .i_inc (w_capture),
    .o_cnt (taken_count)
  );

  brc_sat_cnt #(.W(CNT_WIDTH)) u_wait (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (clear_stats),
    .i_inc (w_wait),
    .o_cnt (wait_count)
  );
endmodule
